// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard controller: data-memory freeze, branch redirect, load-use
// interlock and fetch-miss handling, plus a count of PC-stall cycles.
module core_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        if_inst_ready,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_flush,
    output logic        id_ex_flush,
    output logic        pipe_stall,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      hold_state_s;
    logic        discard_pend_r;
    logic        discard_nxt_s;
    logic        load_use_s;
    logic        data_freeze_s;
    logic [15:0] stall_cnt_r;

    assign data_freeze_s = mem_req & ~mem_ack;
    assign load_use_s    = ex_mem_read & (ex_rt != 5'd0) &
                           ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign stall_cnt     = stall_cnt_r;

    // Rules that keep the current state still leave DWAIT once the access is done.
    always_comb begin
        hold_state_s = state_r;
        case (state_r)
            RUN:     hold_state_s = RUN;
            IWAIT:   hold_state_s = IWAIT;
            DWAIT:   hold_state_s = RUN;
            default: hold_state_s = RUN;
        endcase
    end

    // Priority-ordered hazard rules; the first match sets outputs and next state.
    always_comb begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_flush      = 1'b0;
        id_ex_flush   = 1'b0;
        pipe_stall    = 1'b0;
        state_nxt_s   = state_r;
        discard_nxt_s = discard_pend_r;
        if (rst) begin
            if_flush      = 1'b1;
            id_ex_flush   = 1'b1;
            state_nxt_s   = RUN;
            discard_nxt_s = 1'b0;
        end else if (data_freeze_s) begin
            // EX is frozen, so a pending branch is re-evaluated after release.
            pipe_stall  = 1'b1;
            state_nxt_s = DWAIT;
        end else if (ex_branch_taken) begin
            pc_we       = 1'b1;
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt_s = hold_state_s;
            if (state_r == IWAIT) begin
                discard_nxt_s = 1'b1;
            end else begin
                discard_nxt_s = discard_pend_r;
            end
        end else if (load_use_s) begin
            id_ex_flush = 1'b1;
            state_nxt_s = hold_state_s;
        end else if (!if_inst_ready) begin
            if_flush    = 1'b1;
            state_nxt_s = IWAIT;
        end else if (discard_pend_r) begin
            // The word now arriving was fetched before the redirect; drop it.
            if_flush      = 1'b1;
            discard_nxt_s = 1'b0;
            state_nxt_s   = RUN;
        end else begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            state_nxt_s = RUN;
        end
    end

    // State, discard flag and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RUN;
            discard_pend_r <= 1'b0;
            stall_cnt_r    <= 16'd0;
        end else begin
            state_r        <= state_nxt_s;
            discard_pend_r <= discard_nxt_s;
            if (!pc_we && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed self-checking bench for core_hazard_ctrl.
module tb_core_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        if_inst_ready;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_we;
    logic        if_id_we;
    logic        if_flush;
    logic        id_ex_flush;
    logic        pipe_stall;
    logic [15:0] stall_cnt;

    int          checks_r = 0;
    int          errors_r = 0;
    logic [15:0] exp_cnt  = 16'd0;

    core_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .if_inst_ready   (if_inst_ready),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_flush        (if_flush),
        .id_ex_flush     (id_ex_flush),
        .pipe_stall      (pipe_stall),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
        if_inst_ready   = 1'b1;
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp = {pc_we, if_id_we, if_flush, id_ex_flush, pipe_stall}
    task automatic step(input string tag, input logic [4:0] exp);
        #1;
        check_eq(tag, {27'd0, pc_we, if_id_we, if_flush, id_ex_flush, pipe_stall},
                 {27'd0, exp});
        if (rst) begin
            exp_cnt = 16'd0;
        end else if (!exp[4] && (exp_cnt != 16'hFFFF)) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        tick();
        check_eq({tag, "_cnt"}, {16'd0, stall_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        idle();
        rst             = 1'b1;
        ex_branch_taken = 1'b1;
        mem_req         = 1'b1;
        if_inst_ready   = 1'b0;
        tick();
        step("rst_outs", 5'b00110);
        rst = 1'b0;
        idle();
        step("normal", 5'b11000);

        // load-use interlock
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        step("lu_rs", 5'b00010);
        ex_rt = 5'd0; id_rs = 5'd0;
        step("lu_r0", 5'b11000);
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        step("lu_rt", 5'b00010);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", 5'b11000);
        id_rs = 5'd7; if_inst_ready = 1'b0;
        step("lu_over_miss", 5'b00010);
        idle();
        step("lu_done", 5'b11000);

        // fetch miss for three cycles
        if_inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("miss", 5'b00100);
        if_inst_ready = 1'b1;
        step("miss_end", 5'b11000);

        // branch during IWAIT sets discard, next ready word is dropped
        if_inst_ready = 1'b0;
        step("iw_enter", 5'b00100);
        ex_branch_taken = 1'b1;
        step("iw_branch", 5'b10110);
        ex_branch_taken = 1'b0; if_inst_ready = 1'b1;
        step("iw_discard", 5'b00100);
        step("iw_resume", 5'b11000);

        // second redirect while discard pending keeps the flag
        if_inst_ready = 1'b0;
        step("iw2_enter", 5'b00100);
        ex_branch_taken = 1'b1;
        step("iw2_branch", 5'b10110);
        if_inst_ready = 1'b1;
        step("iw2_branch2", 5'b10110);
        ex_branch_taken = 1'b0;
        step("iw2_discard", 5'b00100);
        step("iw2_resume", 5'b11000);

        // discard flag survives a data freeze
        if_inst_ready = 1'b0;
        step("iw3_enter", 5'b00100);
        ex_branch_taken = 1'b1;
        step("iw3_branch", 5'b10110);
        ex_branch_taken = 1'b0; mem_req = 1'b1;
        step("iw3_freeze", 5'b00001);
        mem_ack = 1'b1; if_inst_ready = 1'b1;
        step("iw3_hit_discard", 5'b00100);
        idle();
        step("iw3_resume", 5'b11000);

        // data freeze masks branch and load-use, then branch fires on ack
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        for (int i = 0; i < 4; i++) step("freeze", 5'b00001);
        mem_ack = 1'b1;
        step("freeze_ack", 5'b10110);
        idle();
        step("freeze_after", 5'b11000);

        // saturation of the stall counter
        if_inst_ready = 1'b0;
        repeat (70000) tick();
        exp_cnt = 16'hFFFF;
        check_eq("sat", {16'd0, stall_cnt}, {16'd0, exp_cnt});
        step("sat_hold", 5'b00100);
        ex_branch_taken = 1'b1;
        step("sat_branch", 5'b10110);
        ex_branch_taken = 1'b0;

        // reset mid-IWAIT with discard pending abandons both
        rst = 1'b1;
        step("rst_iwait", 5'b00110);
        rst = 1'b0;
        idle();
        step("rst_run", 5'b11000);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
